// File: rtl/imm_ext_pkg.sv
// Shared mode encoding and default widths for the immediate-extension stage.
package imm_ext_pkg;

    localparam int unsigned IMM_IN_W  = 16;
    localparam int unsigned IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        IMM_SEXT   = 2'd0,
        IMM_ZEXT   = 2'd1,
        IMM_LUI    = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender (sign/zero/LUI/branch-scaled).
// LUI and BRANCH shifts exist only when IMM_EXT_PIPE_SHIFT_EN is defined; otherwise they fall back to SEXT and flag err_c.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_c,
    output logic             err_c
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] zext_w;

    assign sext_w = {{EXT_W{imm_i[IN_W-1]}}, imm_i};
    assign zext_w = OUT_W'(imm_i);

`ifdef IMM_EXT_PIPE_SHIFT_EN
    logic [OUT_W-1:0] lui_w;
    logic [OUT_W-1:0] branch_w;

    assign lui_w    = zext_w << EXT_W;
    assign branch_w = sext_w << 2;
`endif

    always_comb begin
        ext_c = sext_w;
        err_c = 1'b0;
        case (imm_mode_e'(mode_i))
            IMM_SEXT:   ext_c = sext_w;
            IMM_ZEXT:   ext_c = zext_w;
`ifdef IMM_EXT_PIPE_SHIFT_EN
            IMM_LUI:    ext_c = lui_w;
            IMM_BRANCH: ext_c = branch_w;
`else
            // Shift modes not built: keep SEXT value, let decode trap on err.
            IMM_LUI:    err_c = 1'b1;
            IMM_BRANCH: err_c = 1'b1;
`endif
            default:    ext_c = sext_w;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage: extender feeding an output register plus skid register.
// Optional shift modes controlled by IMM_EXT_PIPE_SHIFT_EN (see imm_ext_core).
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode_err
);

    generate
        if (OUT_W < IN_W + 2) begin : g_bad_width
            $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    logic [OUT_W-1:0] ext_c;
    logic             err_c;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .ext_c  (ext_c),
        .err_c  (err_c)
    );

    logic             o_valid_q, o_valid_d;
    logic [OUT_W-1:0] o_imm_q,   o_imm_d;
    logic [TAG_W-1:0] o_tag_q,   o_tag_d;
    logic             o_err_q,   o_err_d;
    logic             s_valid_q, s_valid_d;
    logic [OUT_W-1:0] s_imm_q,   s_imm_d;
    logic [TAG_W-1:0] s_tag_q,   s_tag_d;
    logic             s_err_q,   s_err_d;
    logic             accept_c;
    logic             drain_c;

    // Ready depends only on state and reset, never on out_ready.
    assign in_ready = !s_valid_q && !rst;
    assign accept_c = in_valid && in_ready;
    assign drain_c  = o_valid_q && out_ready;

    always_comb begin
        o_valid_d = o_valid_q;
        o_imm_d   = o_imm_q;
        o_tag_d   = o_tag_q;
        o_err_d   = o_err_q;
        s_valid_d = s_valid_q;
        s_imm_d   = s_imm_q;
        s_tag_d   = s_tag_q;
        s_err_d   = s_err_q;
        if (drain_c) begin
            if (s_valid_q) begin
                o_imm_d   = s_imm_q;
                o_tag_d   = s_tag_q;
                o_err_d   = s_err_q;
                s_valid_d = 1'b0;
            end else if (accept_c) begin
                o_imm_d = ext_c;
                o_tag_d = in_tag;
                o_err_d = err_c;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!o_valid_q) begin
                o_valid_d = 1'b1;
                o_imm_d   = ext_c;
                o_tag_d   = in_tag;
                o_err_d   = err_c;
            end else begin
                s_valid_d = 1'b1;
                s_imm_d   = ext_c;
                s_tag_d   = in_tag;
                s_err_d   = err_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_imm_q   <= '0;
            o_tag_q   <= '0;
            o_err_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_imm_q   <= '0;
            s_tag_q   <= '0;
            s_err_q   <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_imm_q   <= o_imm_d;
            o_tag_q   <= o_tag_d;
            o_err_q   <= o_err_d;
            s_valid_q <= s_valid_d;
            s_imm_q   <= s_imm_d;
            s_tag_q   <= s_tag_d;
            s_err_q   <= s_err_d;
        end
    end

    assign out_valid    = o_valid_q;
    assign out_imm      = o_imm_q;
    assign out_tag      = o_tag_q;
    assign out_mode_err = o_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: driver pushes expected items on accept, monitor checks every presented output.
module tb_imm_ext_pipe;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned TAG_W = 5;

`ifdef IMM_EXT_PIPE_SHIFT_EN
    localparam logic [31:0] E_LUI  = 32'h1234_0000;
    localparam logic [31:0] E_BR1  = 32'hFFFF_FFFC;
    localparam logic [31:0] E_BR2  = 32'h0001_0000;
    localparam logic        E_SERR = 1'b0;
`else
    localparam logic [31:0] E_LUI  = 32'h0000_1234;
    localparam logic [31:0] E_BR1  = 32'hFFFF_FFFF;
    localparam logic [31:0] E_BR2  = 32'h0000_4000;
    localparam logic        E_SERR = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_mode_err;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    int   waits;

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mode      (in_mode),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_tag      (out_tag),
        .out_mode_err (out_mode_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        exp_t        e;
        logic [31:0] sx;
        sx    = {{16{imm[15]}}, imm};
        e.tag = tag;
        e.err = 1'b0;
        e.imm = sx;
        case (mode)
            2'd1: e.imm = {16'h0000, imm};
`ifdef IMM_EXT_PIPE_SHIFT_EN
            2'd2: e.imm = {imm, 16'h0000};
            2'd3: e.imm = {sx[29:0], 2'b00};
`else
            2'd2, 2'd3: e.err = 1'b1;
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one item from posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                        input logic [31:0] e_imm, input logic e_err, output int nwait);
        bit   done;
        exp_t e;
        done     = 1'b0;
        nwait    = 0;
        e.imm    = e_imm;
        e.tag    = tag;
        e.err    = e_err;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end else begin
                nwait++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: tag %0d never accepted", tag);
        end
    endtask

    task automatic send_m(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag, output int nwait);
        exp_t e;
        e = model(imm, mode, tag);
        send(imm, mode, tag, e.imm, e.err, nwait);
    endtask

    // Every presented output must match the oldest outstanding item.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL mon_stale: out_valid with tag %0d imm %h but nothing outstanding", out_tag, out_imm);
            end else begin
                me = q[0];
                if ({out_imm, out_tag, out_mode_err} !== {me.imm, me.tag, me.err}) begin
                    n_err++;
                    $display("FAIL mon_data: got imm %h tag %0d err %0b expected imm %h tag %0d err %0b",
                             out_imm, out_tag, out_mode_err, me.imm, me.tag, me.err);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_mode_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with out_ready high
        send(16'h8001, 2'd0, 5'd1, 32'hFFFF_8001, 1'b0, waits);
        chk("sext_valid", 32'(out_valid), 32'd1);
        chk("sext_imm", out_imm, 32'hFFFF_8001);
        chk("sext_err", 32'(out_mode_err), 32'd0);
        send(16'h8001, 2'd1, 5'd2, 32'h0000_8001, 1'b0, waits);
        chk("zext_imm", out_imm, 32'h0000_8001);
        chk("zext_wait", 32'(waits), 32'd0);
        send(16'h1234, 2'd2, 5'd3, E_LUI, E_SERR, waits);
        chk("lui_imm", out_imm, E_LUI);
        chk("lui_err", 32'(out_mode_err), 32'(E_SERR));
        send(16'hFFFF, 2'd3, 5'd4, E_BR1, E_SERR, waits);
        chk("br1_imm", out_imm, E_BR1);
        send(16'h4000, 2'd3, 5'd5, E_BR2, E_SERR, waits);
        chk("br2_imm", out_imm, E_BR2);
        chk("br2_err", 32'(out_mode_err), 32'(E_SERR));
        repeat (3) @(posedge clk);
        #1;
        chk("dir_drained", 32'(q.size()), 32'd0);

        // Backpressure: two items fill O and S, third is held off
        out_ready = 1'b0;
        send(16'h0011, 2'd0, 5'd1, 32'h0000_0011, 1'b0, waits);
        send(16'hF022, 2'd1, 5'd2, 32'h0000_F022, 1'b0, waits);
        chk("bp_second_wait", 32'(waits), 32'd0);
        in_valid = 1'b1;
        in_imm   = 16'h8033;
        in_mode  = 2'd0;
        in_tag   = 5'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_tag", 32'(out_tag), 32'd1);
            chk("bp_hold_imm", out_imm, 32'h0000_0011);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h8033, 2'd0, 5'd3, 32'hFFFF_8033, 1'b0, waits);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Streaming random items at full rate
        for (int i = 0; i < 100; i++) begin
            send_m(16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), waits);
            chk("stream_wait", 32'(waits), 32'd0);
            chk("stream_valid", 32'(out_valid), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stream_drained", 32'(q.size()), 32'd0);

        // Reset with O and S both full; input during reset must be ignored
        out_ready = 1'b0;
        send(16'h0A0A, 2'd0, 5'd10, 32'h0000_0A0A, 1'b0, waits);
        send(16'h0B0B, 2'd1, 5'd11, 32'h0000_0B0B, 1'b0, waits);
        rst = 1'b1;
        q.delete();
        in_valid = 1'b1;
        in_imm   = 16'h0C0C;
        in_mode  = 2'd0;
        in_tag   = 5'd12;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        chk("after_rst_out_valid", 32'(out_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send(16'h0005, 2'd0, 5'd7, 32'h0000_0005, 1'b0, waits);
        chk("post_rst_imm", out_imm, 32'h0000_0005);
        chk("post_rst_tag", 32'(out_tag), 32'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
